alu_seq_multi: RTL and testbench

Parametrised, handshaked successor to the 8-bit four-output ALU. It takes one instruction per cycle over a valid/ready interface and supports any operand width and any number of destination registers. Destination registers hold their value between writes. It adds an iterative shift-add multiplier, controlled by a small FSM, and full carry/overflow/zero/negative flags. It sits between the instruction decoder and the output/display logic.

---
 rtl/alu_seq_multi_if.sv | 34 +++
 rtl/alu_seq_multi.sv | 210 +++++++++++++++++++++
 tb/tb_alu_seq_multi.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_multi_if.sv
// Instruction/result bundle between the decoder (master) and alu_seq_multi (slave).
// Carries the valid/ready handshake, the operands, the register file view and the flags.
interface alu_seq_multi_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4
);
    localparam int DEST_W = $clog2(NUM_OUT);

    logic                     in_valid;
    logic                     in_ready;
    logic [DEST_W+3:0]        instruction;
    logic [WIDTH-1:0]         data0;
    logic [WIDTH-1:0]         data1;
    logic [NUM_OUT*WIDTH-1:0] out_regs;
    logic                     res_valid;
    logic [DEST_W-1:0]        res_dest;
    logic [WIDTH-1:0]         res_data;
    logic                     carry_flag;
    logic                     overflow_flag;
    logic                     zero_flag;
    logic                     neg_flag;

    modport master (
        output in_valid, instruction, data0, data1,
        input  in_ready, out_regs, res_valid, res_dest, res_data,
        input  carry_flag, overflow_flag, zero_flag, neg_flag
    );

    modport slave (
        input  in_valid, instruction, data0, data1,
        output in_ready, out_regs, res_valid, res_dest, res_data,
        output carry_flag, overflow_flag, zero_flag, neg_flag
    );
endinterface

// File: rtl/alu_seq_multi.sv
// Handshaked ALU with a destination register file, single-cycle ops and an
// iterative shift-add multiplier that holds off new instructions while busy.
module alu_seq_multi #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_multi_if.slave bus
);
    localparam int DEST_W = $clog2(NUM_OUT);
    localparam int CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH:0]   SHIFT_LIM = (WIDTH + 1)'(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [CNT_W-1:0]                  r_cnt;
    logic [CNT_W-1:0]                  w_cnt_nxt;
    logic [2*WIDTH-1:0]                r_p;
    logic [2*WIDTH-1:0]                w_p_nxt;
    logic [2*WIDTH-1:0]                w_p_step;
    logic [WIDTH-1:0]                  r_a;
    logic [WIDTH-1:0]                  r_b;
    logic [DEST_W-1:0]                 r_dest;
    logic                              r_mulh;
    logic [NUM_OUT-1:0][WIDTH-1:0]     r_regs;
    logic                              r_res_valid;
    logic [DEST_W-1:0]                 r_res_dest;
    logic [WIDTH-1:0]                  r_res_data;
    logic                              r_carry;
    logic                              r_ovf;
    logic                              r_zero;
    logic                              r_neg;

    logic [DEST_W-1:0]                 w_dest;
    logic [1:0]                        w_cls;
    logic [1:0]                        w_sel;
    logic                              w_accept;
    logic                              w_is_mul;
    logic                              w_mul_start;
    logic [WIDTH:0]                    w_sum;
    logic [WIDTH:0]                    w_diff;
    logic                              w_shift_big;
    logic [WIDTH-1:0]                  w_alu_res;
    logic                              w_alu_c;
    logic                              w_alu_v;
    logic                              w_wb_en;
    logic [DEST_W-1:0]                 w_wb_dest;
    logic [WIDTH-1:0]                  w_wb_data;
    logic                              w_wb_c;
    logic                              w_wb_v;

    // True when both operands have matching end bits and share the same sign.
    function automatic logic special_test(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a[WIDTH-1] == a[0]) && (b[WIDTH-1] == b[0]) && (a[WIDTH-1] == b[WIDTH-1]);
    endfunction

    assign {w_dest, w_cls, w_sel} = bus.instruction;
    assign w_accept    = bus.in_valid && (r_state == IDLE);
    assign w_is_mul    = (w_cls == 2'b10) && (w_sel[1] == 1'b0);
    assign w_sum       = {1'b0, bus.data0} + {1'b0, bus.data1};
    assign w_diff      = {1'b0, bus.data0} - {1'b0, bus.data1};
    assign w_shift_big = ({1'b0, bus.data1} >= SHIFT_LIM);
    assign w_p_step    = r_p + (r_b[r_cnt] ? ({{WIDTH{1'b0}}, r_a} << r_cnt)
                                           : {(2*WIDTH){1'b0}});

    // Single-cycle result and ADD/SUB flags for the instruction on the bus.
    always_comb begin
        w_alu_res = {WIDTH{1'b0}};
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (w_cls)
            2'b00: begin
                case (w_sel)
                    2'b00: w_alu_res = w_shift_big ? {WIDTH{1'b0}} : (bus.data0 >> bus.data1);
                    2'b01: w_alu_res = w_shift_big ? {WIDTH{1'b0}} : (bus.data0 << bus.data1);
                    2'b10: begin
                        w_alu_res = w_sum[WIDTH-1:0];
                        w_alu_c   = w_sum[WIDTH];
                        w_alu_v   = (bus.data0[WIDTH-1] == bus.data1[WIDTH-1]) &&
                                    (w_sum[WIDTH-1] != bus.data0[WIDTH-1]);
                    end
                    2'b11: begin
                        // Bit WIDTH of the zero-extended difference is the borrow (A < B).
                        w_alu_res = w_diff[WIDTH-1:0];
                        w_alu_c   = w_diff[WIDTH];
                        w_alu_v   = (bus.data0[WIDTH-1] != bus.data1[WIDTH-1]) &&
                                    (w_diff[WIDTH-1] != bus.data0[WIDTH-1]);
                    end
                    default: w_alu_res = {WIDTH{1'b0}};
                endcase
            end
            2'b01: begin
                case (w_sel)
                    2'b00:   w_alu_res = bus.data0 & bus.data1;
                    2'b01:   w_alu_res = bus.data0 | bus.data1;
                    2'b10:   w_alu_res = bus.data0 ^ bus.data1;
                    2'b11:   w_alu_res = {{(WIDTH-1){1'b0}}, 1'b1};
                    default: w_alu_res = {WIDTH{1'b0}};
                endcase
            end
            2'b10:   w_alu_res = {WIDTH{1'b0}};
            2'b11:   w_alu_res = {{(WIDTH-1){1'b0}}, special_test(bus.data0, bus.data1)};
            default: w_alu_res = {WIDTH{1'b0}};
        endcase
    end

    // FSM next state, multiply stepping and writeback selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_p_nxt     = r_p;
        w_mul_start = 1'b0;
        w_wb_en     = 1'b0;
        w_wb_dest   = w_dest;
        w_wb_data   = w_alu_res;
        w_wb_c      = w_alu_c;
        w_wb_v      = w_alu_v;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = MUL;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_p_nxt     = {(2*WIDTH){1'b0}};
                    w_mul_start = 1'b1;
                end else if (w_accept) begin
                    w_wb_en     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MUL: begin
                w_p_nxt   = w_p_step;
                w_wb_dest = r_dest;
                w_wb_data = r_mulh ? w_p_step[2*WIDTH-1:WIDTH] : w_p_step[WIDTH-1:0];
                w_wb_c    = 1'b0;
                w_wb_v    = 1'b0;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_wb_en     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, multiplier operands, register file and result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_p         <= {(2*WIDTH){1'b0}};
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_dest      <= {DEST_W{1'b0}};
            r_mulh      <= 1'b0;
            r_regs      <= {(NUM_OUT*WIDTH){1'b0}};
            r_res_valid <= 1'b0;
            r_res_dest  <= {DEST_W{1'b0}};
            r_res_data  <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_p         <= w_p_nxt;
            r_res_valid <= w_wb_en;
            if (w_mul_start) begin
                r_a    <= bus.data0;
                r_b    <= bus.data1;
                r_dest <= w_dest;
                r_mulh <= w_sel[0];
            end else begin
                r_a    <= r_a;
            end
            if (w_wb_en) begin
                r_regs[w_wb_dest] <= w_wb_data;
                r_res_dest        <= w_wb_dest;
                r_res_data        <= w_wb_data;
                r_carry           <= w_wb_c;
                r_ovf             <= w_wb_v;
                r_zero            <= (w_wb_data == {WIDTH{1'b0}});
                r_neg             <= w_wb_data[WIDTH-1];
            end else begin
                r_res_data        <= r_res_data;
            end
        end
    end

    assign bus.in_ready      = (r_state == IDLE);
    assign bus.out_regs      = r_regs;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_dest      = r_res_dest;
    assign bus.res_data      = r_res_data;
    assign bus.carry_flag    = r_carry;
    assign bus.overflow_flag = r_ovf;
    assign bus.zero_flag     = r_zero;
    assign bus.neg_flag      = r_neg;
endmodule

// File: tb/tb_alu_seq_multi.sv
// Directed bench for alu_seq_multi (WIDTH=8, NUM_OUT=4): a vector table for the
// single-cycle ops plus hand sequences for multiply timing and reset abort.
module tb_alu_seq_multi;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [7:0] model [4];

    alu_seq_multi_if #(.WIDTH(8), .NUM_OUT(4)) bus ();

    alu_seq_multi #(.WIDTH(8), .NUM_OUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dest;
        logic [1:0] cls;
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s reg%0d", tag, k), 64'(bus.out_regs[k*8 +: 8]), 64'(model[k]));
        end
    endtask

    task automatic drive(input logic [1:0] d, input logic [1:0] cls, input logic [1:0] sel,
                         input logic [7:0] a, input logic [7:0] b);
        bus.in_valid    = 1'b1;
        bus.instruction = {d, cls, sel};
        bus.data0       = a;
        bus.data1       = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int k = 0; k < 4; k++) model[k] = 8'h00;

        //            dest   cls    sel    a      b      res    c     v     z     n
        vt[0]  = '{2'd2, 2'b00, 2'b10, 8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0}; // ADD
        vt[1]  = '{2'd2, 2'b00, 2'b11, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0}; // SUB ovf
        vt[2]  = '{2'd0, 2'b01, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0}; // AND
        vt[3]  = '{2'd1, 2'b01, 2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1}; // OR
        vt[4]  = '{2'd2, 2'b01, 2'b10, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1}; // XOR
        vt[5]  = '{2'd3, 2'b00, 2'b01, 8'h01, 8'h09, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // SHL >= W
        vt[6]  = '{2'd0, 2'b00, 2'b00, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0}; // SHR
        vt[7]  = '{2'd1, 2'b00, 2'b00, 8'hFF, 8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // SHR == W
        vt[8]  = '{2'd2, 2'b00, 2'b11, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1}; // SUB borrow
        vt[9]  = '{2'd3, 2'b00, 2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1}; // ADD ovf
        vt[10] = '{2'd0, 2'b01, 2'b11, 8'h55, 8'hAA, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}; // const 1
        vt[11] = '{2'd1, 2'b10, 2'b10, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // const 0
        vt[12] = '{2'd2, 2'b11, 2'b00, 8'h81, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}; // special 1
        vt[13] = '{2'd3, 2'b11, 2'b00, 8'h81, 8'h7E, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // special 0
        vt[14] = '{2'd0, 2'b00, 2'b01, 8'h03, 8'h01, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0}; // SHL

        rst             = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = 6'h00;
        bus.data0       = 8'h00;
        bus.data1       = 8'h00;
        repeat (2) step();
        rst = 1'b1;
        step();
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset res_valid", 64'(bus.res_valid), 64'd0);
        check("reset flags", 64'({bus.carry_flag, bus.overflow_flag, bus.zero_flag, bus.neg_flag}), 64'd0);
        check("reset res_data", 64'(bus.res_data), 64'd0);
        check_regs("reset");

        // Table vectors issue back-to-back, one per cycle.
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].dest, vt[i].cls, vt[i].sel, vt[i].a, vt[i].b);
            step();
            model[vt[i].dest] = vt[i].res;
            check($sformatf("v%0d res_valid", i), 64'(bus.res_valid), 64'd1);
            check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'd1);
            check($sformatf("v%0d res_data", i), 64'(bus.res_data), 64'(vt[i].res));
            check($sformatf("v%0d res_dest", i), 64'(bus.res_dest), 64'(vt[i].dest));
            check($sformatf("v%0d carry", i), 64'(bus.carry_flag), 64'(vt[i].c));
            check($sformatf("v%0d ovf", i), 64'(bus.overflow_flag), 64'(vt[i].v));
            check($sformatf("v%0d zero", i), 64'(bus.zero_flag), 64'(vt[i].z));
            check($sformatf("v%0d neg", i), 64'(bus.neg_flag), 64'(vt[i].n));
            check_regs($sformatf("v%0d", i));
        end
        bus.in_valid = 1'b0;
        step();
        check("idle res_valid", 64'(bus.res_valid), 64'd0);
        check("idle res_data hold", 64'(bus.res_data), 64'h06);

        // MULH 0xFF*0xFF -> 0xFE, with an ADD held on the bus while busy.
        drive(2'd1, 2'b10, 2'b01, 8'hFF, 8'hFF);
        step();
        check("mulh busy0 in_ready", 64'(bus.in_ready), 64'd0);
        check("mulh busy0 res_valid", 64'(bus.res_valid), 64'd0);
        drive(2'd0, 2'b00, 2'b10, 8'h01, 8'h01);
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("mulh busy%0d in_ready", k), 64'(bus.in_ready), 64'd0);
            check($sformatf("mulh busy%0d res_valid", k), 64'(bus.res_valid), 64'd0);
        end
        step();
        model[1] = 8'hFE;
        check("mulh res_valid", 64'(bus.res_valid), 64'd1);
        check("mulh res_data", 64'(bus.res_data), 64'hFE);
        check("mulh res_dest", 64'(bus.res_dest), 64'd1);
        check("mulh flags", 64'({bus.carry_flag, bus.overflow_flag, bus.zero_flag, bus.neg_flag}), 64'b0001);
        check("mulh in_ready", 64'(bus.in_ready), 64'd1);
        check_regs("mulh");

        // MUL 0xFF*0xFF -> 0x01, accepted in the first cycle back in IDLE.
        drive(2'd0, 2'b10, 2'b00, 8'hFF, 8'hFF);
        step();
        bus.in_valid = 1'b0;
        check("mul pulse once", 64'(bus.res_valid), 64'd0);
        check("mul accepted", 64'(bus.in_ready), 64'd0);
        repeat (7) step();
        check("mul pre res_valid", 64'(bus.res_valid), 64'd0);
        step();
        model[0] = 8'h01;
        check("mul res_valid", 64'(bus.res_valid), 64'd1);
        check("mul res_data", 64'(bus.res_data), 64'h01);
        check("mul flags", 64'({bus.carry_flag, bus.overflow_flag, bus.zero_flag, bus.neg_flag}), 64'b0000);
        check_regs("mul");

        // Reset three edges into a multiply aborts it.
        drive(2'd3, 2'b10, 2'b00, 8'h10, 8'h10);
        step();
        bus.in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) model[k] = 8'h00;
        check("abort res_valid", 64'(bus.res_valid), 64'd0);
        check("abort flags", 64'({bus.carry_flag, bus.overflow_flag, bus.zero_flag, bus.neg_flag}), 64'd0);
        check_regs("abort");
        rst = 1'b1;
        step();
        check("abort in_ready", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("abort quiet%0d", k), 64'(bus.res_valid), 64'd0);
        end
        check_regs("abort late");

        drive(2'd1, 2'b11, 2'b00, 8'h81, 8'hFF);
        step();
        bus.in_valid = 1'b0;
        model[1] = 8'h01;
        check("post special res_data", 64'(bus.res_data), 64'h01);
        check("post special zero", 64'(bus.zero_flag), 64'd0);
        check_regs("post special");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
